// File: rtl/machine.sv
// machine: Y86-64 execute-stage ALU (ADD/SUB/AND/XOR) with registered result and signed-overflow flag
module machine #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [1:0]       control,
  output logic [WIDTH-1:0] out,
  output logic             OF
);
  logic             sub;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] res;
  logic             ovf;
  assign sub = control == 2'b01;
  assign b   = sub ? ~y : y;
  assign sum = x + b + {{(WIDTH-1){1'b0}}, sub};
  // select the function result; overflow only for the shared adder, where the effective operands agree in sign but the sum does not
  always_comb begin
    res = control[1] ? (control[0] ? x ^ y : x & y) : sum;
    ovf = ~control[1] & (x[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != x[WIDTH-1]);
  end
  // one-cycle result register, cleared immediately by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out <= '0;
      OF  <= 1'b0;
    end else begin
      out <= res;
      OF  <= ovf;
    end
  end
endmodule

// File: tb/tb_machine.sv
// tb_machine: directed and randomized checks of machine against an exact-integer reference model
module tb_machine;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] x, y;
  logic [1:0]  control;
  logic [63:0] out;
  logic        OF;
  int tests = 0;
  int fails = 0;

  machine dut (.clk(clk), .reset_n(reset_n), .x(x), .y(y), .control(control), .out(out), .OF(OF));

  always #5 clk = ~clk;

  // exact signed arithmetic in 66 bits; overflow means the true result does not fit in 64 bits
  function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic [1:0] c,
                                output logic [63:0] r, output logic o);
    logic signed [65:0] sa, sb, t;
    sa = $signed({{2{a[63]}}, a});
    sb = $signed({{2{b[63]}}, b});
    r = '0;
    o = 1'b0;
    if (c == 2'd0 || c == 2'd1) begin
      t = (c == 2'd0) ? sa + sb : sa - sb;
      r = t[63:0];
      o = (t > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (t < -66'sh0_8000_0000_0000_0000);
    end else if (c == 2'd2) r = a & b;
    else r = a ^ b;
  endfunction

  task automatic chk(input string tag, input logic [63:0] eo, input logic ef);
    tests++;
    assert (out === eo) else begin
      fails++;
      $error("FAIL %s out: got %h want %h", tag, out, eo);
    end
    tests++;
    assert (OF === ef) else begin
      fails++;
      $error("FAIL %s OF: got %b want %b", tag, OF, ef);
    end
  endtask

  task automatic step(input string tag, input logic [63:0] a, input logic [63:0] b, input logic [1:0] c);
    logic [63:0] er;
    logic        eo;
    @(negedge clk);
    x = a;
    y = b;
    control = c;
    model(a, b, c, er, eo);
    @(posedge clk);
    #1;
    chk(tag, er, eo);
  endtask

  function automatic logic [63:0] rnd();
    logic [31:0] r;
    logic [63:0] v;
    r = $urandom;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0: return v;
      1: return 64'h7FFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
      2: return 64'h8000_0000_0000_0000 + 64'($urandom_range(0, 3));
      default: return {{32{r[31]}}, r};
    endcase
  endfunction

  initial begin
    logic [63:0] hx, hy, ho;
    logic        hf;
    reset_n = 1'b0;
    x = 64'hDEAD_BEEF_0123_4567;
    y = 64'h1;
    control = 2'b01;
    #1;
    chk("reset_async", 64'h0, 1'b0);
    @(posedge clk);
    #1;
    chk("reset_hold_edge", 64'h0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    step("first_after_reset", 64'd7, 64'd9, 2'b00);
    step("add_5_m3", 64'd5, -64'sd3, 2'b00);
    step("add_max_1", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00);
    step("sub_10_20", 64'd10, 64'd20, 2'b01);
    step("sub_min_1", 64'h8000_0000_0000_0000, 64'd1, 2'b01);
    step("sub_0_min", 64'd0, 64'h8000_0000_0000_0000, 2'b01);
    step("sub_x_x", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 2'b01);
    step("add_m1_1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b00);
    step("and", 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 2'b10);
    step("xor", 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 2'b11);
    step("sub_max_m1", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01);
    step("add_min_min", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b00);
    // inputs changed between edges must not disturb held outputs
    @(negedge clk);
    x = 64'h5;
    y = 64'h5;
    control = 2'b11;
    #2;
    chk("hold_between_edges", 64'h0, 1'b1);
    for (int i = 0; i < 8; i++) step("b2b", rnd(), rnd(), 2'(i));
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) begin
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrun_reset", 64'h0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
      end
      hx = rnd();
      hy = rnd();
      step("rand", hx, hy, 2'($urandom_range(0, 3)));
    end
    model(64'h0, 64'h0, 2'b00, ho, hf);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
